sweep_sequencer: RTL and testbench

SWEEP_SEQUENCER -- requirements
Module: sweep_sequencer

---
 rtl/sweep_sequencer.sv | 139 +++++++++++++
 tb/tb_sweep_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_sequencer.sv
// Multi-segment sweep sequencer: steps through a small table of sweep
// configurations, handing each one to the sweep datapath in turn.
module sweep_sequencer #(
    parameter int NSEG = 4
) (
    input  logic        i_stepCLK,
    input  logic        i_reset,
    input  logic        i_cfgWe,
    input  logic [1:0]  i_cfgSeg,
    input  logic [2:0]  i_cfgSel,
    input  logic [11:0] i_cfgData,
    input  logic [1:0]  i_numSeg,
    input  logic        i_loop,
    input  logic        i_go,
    input  logic        i_abort,
    input  logic        i_swStepping,
    output logic        o_swReset,
    output logic        o_swUpdir,
    output logic [11:0] o_swStart,
    output logic [11:0] o_swStep,
    output logic [11:0] o_swSteps,
    output logic [11:0] o_swRepeats,
    output logic [1:0]  o_segIdx,
    output logic        o_busy,
    output logic        o_done
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t      state, state_n;
    logic [1:0]  seg_n;
    logic        done_n;
    logic        seg_end;
    logic [12:0] pulse_cnt;

    logic [11:0] tbl_start   [NSEG];
    logic [11:0] tbl_step    [NSEG];
    logic [11:0] tbl_steps   [NSEG];
    logic [11:0] tbl_repeats [NSEG];
    logic        tbl_updir   [NSEG];

    always_comb begin
        state_n = state;
        seg_n   = o_segIdx;
        done_n  = 1'b0;
        seg_end = (state == RUN) && i_swStepping && (pulse_cnt == {1'b0, o_swSteps});
        case (state)
            IDLE: begin
                if (i_go && !i_abort) begin
                    state_n = LOAD;
                    seg_n   = '0;
                end
            end
            LOAD: state_n = i_abort ? IDLE : RUN;
            RUN: begin
                if (i_abort) begin
                    state_n = IDLE;
                end else if (seg_end) begin
                    if (o_segIdx < i_numSeg) begin
                        state_n = LOAD;
                        seg_n   = o_segIdx + 2'd1;
                    end else if (i_loop) begin
                        state_n = LOAD;
                        seg_n   = '0;
                    end else begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next-state decision, so the entry is
    // already presented on o_sw* during the LOAD cycle itself.
    always_ff @(posedge i_stepCLK) begin
        if (i_reset) begin
            state       <= IDLE;
            o_swReset   <= 1'b1;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_segIdx    <= '0;
            o_swUpdir   <= 1'b0;
            o_swStart   <= '0;
            o_swStep    <= '0;
            o_swSteps   <= '0;
            o_swRepeats <= '0;
            pulse_cnt   <= '0;
        end else begin
            state     <= state_n;
            o_swReset <= (state_n != RUN);
            o_busy    <= (state_n != IDLE);
            o_done    <= done_n;
            if (state_n == LOAD) begin
                o_segIdx <= seg_n;
                if (int'(seg_n) < NSEG) begin
                    o_swUpdir   <= tbl_updir[seg_n];
                    o_swStart   <= tbl_start[seg_n];
                    o_swStep    <= tbl_step[seg_n];
                    o_swSteps   <= tbl_steps[seg_n];
                    o_swRepeats <= tbl_repeats[seg_n];
                end else begin
                    o_swUpdir   <= 1'b0;
                    o_swStart   <= '0;
                    o_swStep    <= '0;
                    o_swSteps   <= '0;
                    o_swRepeats <= '0;
                end
            end
            if (state == LOAD)
                pulse_cnt <= '0;
            else if (state == RUN && i_swStepping && pulse_cnt != 13'd4096)
                pulse_cnt <= pulse_cnt + 13'd1;
        end
    end

    always_ff @(posedge i_stepCLK) begin
        if (i_reset) begin
            for (int unsigned i = 0; i < NSEG; i++) begin
                tbl_start[i]   <= '0;
                tbl_step[i]    <= '0;
                tbl_steps[i]   <= '0;
                tbl_repeats[i] <= '0;
                tbl_updir[i]   <= 1'b0;
            end
        end else if (i_cfgWe && int'(i_cfgSeg) < NSEG) begin
            case (i_cfgSel)
                3'd0: tbl_start[i_cfgSeg]   <= i_cfgData;
                3'd1: tbl_step[i_cfgSeg]    <= i_cfgData;
                3'd2: tbl_steps[i_cfgSeg]   <= i_cfgData;
                3'd3: tbl_repeats[i_cfgSeg] <= i_cfgData;
                3'd4: tbl_updir[i_cfgSeg]   <= i_cfgData[0];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sweep_sequencer.sv
// Self-checking bench for sweep_sequencer: directed scenarios plus randomized
// sequences checked against a table model and segment-level expectations.
module tb_sweep_sequencer;

    logic        i_stepCLK = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_cfgWe = 1'b0;
    logic [1:0]  i_cfgSeg = '0;
    logic [2:0]  i_cfgSel = '0;
    logic [11:0] i_cfgData = '0;
    logic [1:0]  i_numSeg = '0;
    logic        i_loop = 1'b0;
    logic        i_go = 1'b0;
    logic        i_abort = 1'b0;
    logic        i_swStepping = 1'b0;
    logic        o_swReset, o_swUpdir, o_busy, o_done;
    logic [11:0] o_swStart, o_swStep, o_swSteps, o_swRepeats;
    logic [1:0]  o_segIdx;

    int checks = 0;
    int errors = 0;

    logic [11:0] m_start [4];
    logic [11:0] m_step  [4];
    logic [11:0] m_steps [4];
    logic [11:0] m_rep   [4];
    logic        m_updir [4];

    always #5 i_stepCLK = ~i_stepCLK;

    sweep_sequencer #(.NSEG(4)) dut (
        .i_stepCLK(i_stepCLK), .i_reset(i_reset), .i_cfgWe(i_cfgWe),
        .i_cfgSeg(i_cfgSeg), .i_cfgSel(i_cfgSel), .i_cfgData(i_cfgData),
        .i_numSeg(i_numSeg), .i_loop(i_loop), .i_go(i_go), .i_abort(i_abort),
        .i_swStepping(i_swStepping), .o_swReset(o_swReset), .o_swUpdir(o_swUpdir),
        .o_swStart(o_swStart), .o_swStep(o_swStep), .o_swSteps(o_swSteps),
        .o_swRepeats(o_swRepeats), .o_segIdx(o_segIdx), .o_busy(o_busy), .o_done(o_done)
    );

    task automatic tick;
        @(posedge i_stepCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_write(input int seg, input int sel, input logic [11:0] data);
        case (sel)
            0: m_start[seg] = data;
            1: m_step[seg]  = data;
            2: m_steps[seg] = data;
            3: m_rep[seg]   = data;
            4: m_updir[seg] = data[0];
            default: ;
        endcase
    endtask

    task automatic model_clear;
        for (int s = 0; s < 4; s++) begin
            m_start[s] = '0; m_step[s] = '0; m_steps[s] = '0; m_rep[s] = '0; m_updir[s] = 1'b0;
        end
    endtask

    task automatic write_cfg(input int seg, input int sel, input logic [11:0] data);
        i_cfgWe = 1'b1; i_cfgSeg = seg[1:0]; i_cfgSel = sel[2:0]; i_cfgData = data;
        tick;
        i_cfgWe = 1'b0;
        model_write(seg, sel, data);
    endtask

    task automatic write_entry(input int seg, input logic [11:0] st, input logic [11:0] sp,
                               input logic [11:0] n, input logic [11:0] rp, input logic ud);
        write_cfg(seg, 0, st);
        write_cfg(seg, 1, sp);
        write_cfg(seg, 2, n);
        write_cfg(seg, 3, rp);
        write_cfg(seg, 4, {11'd0, ud});
    endtask

    task automatic chk_idle(input string tag, input logic exp_done);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_swreset"}, 32'(o_swReset), 32'd1);
        chk({tag, "_done"}, 32'(o_done), 32'(exp_done));
    endtask

    // Entered in the LOAD cycle; returns #1 after the edge that sampled the
    // segment's final pulse. Optional write hits this entry in the first RUN cycle.
    task automatic do_segment(input int idx, input bit wr, input int wr_sel,
                              input logic [11:0] wr_data, input int max_gap);
        int steps;
        chk("load_busy", 32'(o_busy), 32'd1);
        chk("load_swreset", 32'(o_swReset), 32'd1);
        chk("load_done", 32'(o_done), 32'd0);
        chk("load_segidx", 32'(o_segIdx), 32'(idx));
        chk("load_start", 32'(o_swStart), 32'(m_start[idx]));
        chk("load_step", 32'(o_swStep), 32'(m_step[idx]));
        chk("load_steps", 32'(o_swSteps), 32'(m_steps[idx]));
        chk("load_repeats", 32'(o_swRepeats), 32'(m_rep[idx]));
        chk("load_updir", 32'(o_swUpdir), 32'(m_updir[idx]));
        steps = int'(m_steps[idx]);
        i_swStepping = 1'($urandom_range(0, 1));
        tick;
        i_swStepping = 1'b0;
        chk("run_swreset", 32'(o_swReset), 32'd0);
        chk("run_busy", 32'(o_busy), 32'd1);
        if (wr) begin
            i_cfgWe = 1'b1; i_cfgSeg = idx[1:0]; i_cfgSel = wr_sel[2:0]; i_cfgData = wr_data;
        end
        tick;
        i_cfgWe = 1'b0;
        if (wr) begin
            model_write(idx, wr_sel, wr_data);
            chk("active_hold", 32'(o_swSteps), 32'(steps));
        end
        for (int p = 0; p <= steps; p++) begin
            repeat ($urandom_range(0, max_gap)) begin
                i_go = 1'($urandom_range(0, 1));
                tick;
            end
            i_go = 1'($urandom_range(0, 1));
            i_swStepping = 1'b1;
            tick;
            i_swStepping = 1'b0;
            i_go = 1'b0;
            if (p < steps && (steps < 16 || p == steps - 1)) begin
                chk("mid_swreset", 32'(o_swReset), 32'd0);
                chk("mid_segidx", 32'(o_segIdx), 32'(idx));
            end
        end
    endtask

    task automatic run_seq(input int nseg, input int max_gap);
        i_numSeg = nseg[1:0];
        i_loop = 1'b0;
        i_go = 1'b1;
        i_swStepping = 1'($urandom_range(0, 1));
        tick;
        i_go = 1'b0;
        for (int s = 0; s <= nseg; s++)
            do_segment(s, 1'b0, 0, 12'd0, max_gap);
        chk_idle("end", 1'b1);
        tick;
        chk_idle("after_end", 1'b0);
    endtask

    initial begin
        model_clear();

        // Reset
        i_reset = 1'b1;
        tick; tick;
        chk_idle("rst", 1'b0);
        chk("rst_segidx", 32'(o_segIdx), 32'd0);
        chk("rst_start", 32'(o_swStart), 32'd0);
        i_reset = 1'b0;
        tick;
        chk_idle("post_rst", 1'b0);

        // go with abort does not start
        i_go = 1'b1; i_abort = 1'b1;
        tick;
        i_go = 1'b0; i_abort = 1'b0;
        chk_idle("go_abort", 1'b0);

        // Single segment
        write_entry(0, 12'd100, 12'd10, 12'd3, 12'd2, 1'b1);
        run_seq(0, 2);

        // Three segments, steps 0/1/2
        write_entry(0, 12'd1, 12'd2, 12'd0, 12'd3, 1'b0);
        write_entry(1, 12'd4, 12'd5, 12'd1, 12'd6, 1'b1);
        write_entry(2, 12'd7, 12'd8, 12'd2, 12'd9, 1'b0);
        run_seq(2, 1);

        // Loop over two segments, then stop after segment 1
        i_numSeg = 2'd1; i_loop = 1'b1; i_go = 1'b1;
        tick;
        i_go = 1'b0;
        do_segment(0, 1'b0, 0, 12'd0, 1);
        do_segment(1, 1'b0, 0, 12'd0, 1);
        do_segment(0, 1'b0, 0, 12'd0, 1);
        i_loop = 1'b0;
        do_segment(1, 1'b0, 0, 12'd0, 1);
        chk_idle("loop_end", 1'b1);
        tick;
        chk_idle("loop_after", 1'b0);

        // Abort on the final pulse
        write_cfg(0, 2, 12'd2);
        i_numSeg = 2'd0; i_go = 1'b1;
        tick;
        i_go = 1'b0;
        tick;
        chk("abort_run", 32'(o_swReset), 32'd0);
        repeat (2) begin i_swStepping = 1'b1; tick; end
        i_abort = 1'b1; i_go = 1'b1;
        tick;
        i_swStepping = 1'b0; i_abort = 1'b0; i_go = 1'b0;
        chk_idle("abort_final", 1'b0);
        tick;
        chk_idle("abort_after", 1'b0);

        // Abort during LOAD
        i_go = 1'b1;
        tick;
        i_go = 1'b0; i_abort = 1'b1;
        tick;
        i_abort = 1'b0;
        chk_idle("abort_load", 1'b0);

        // Write to the active entry during RUN: this pass keeps steps=1
        write_cfg(0, 2, 12'd1);
        i_numSeg = 2'd0; i_loop = 1'b1; i_go = 1'b1;
        tick;
        i_go = 1'b0;
        do_segment(0, 1'b1, 2, 12'd5, 1);
        i_loop = 1'b0;
        do_segment(0, 1'b0, 0, 12'd0, 1);
        chk_idle("live_wr_end", 1'b1);
        tick;

        // Write landing with the LOAD of the same entry is not seen by it;
        // the model update is deferred to the next load.
        write_cfg(0, 0, 12'd111);
        write_cfg(0, 2, 12'd0);
        i_numSeg = 2'd0; i_loop = 1'b1; i_go = 1'b1;
        i_cfgWe = 1'b1; i_cfgSeg = 2'd0; i_cfgSel = 3'd0; i_cfgData = 12'd222;
        tick;
        i_go = 1'b0; i_cfgWe = 1'b0;
        do_segment(0, 1'b0, 0, 12'd0, 0);
        m_start[0] = 12'd222;
        i_loop = 1'b0;
        do_segment(0, 1'b0, 0, 12'd0, 0);
        chk_idle("coinc_end", 1'b1);
        tick;

        // Maximum terminal count: 4096 pulses
        write_cfg(0, 2, 12'd4095);
        run_seq(0, 0);

        // Randomized sequences; includes writes to ignored field selects
        for (int r = 0; r < 6; r++) begin
            for (int s = 0; s < 4; s++)
                write_entry(s, 12'($urandom), 12'($urandom), 12'($urandom_range(0, 5)),
                            12'($urandom), 1'($urandom_range(0, 1)));
            write_cfg($urandom_range(0, 3), $urandom_range(5, 7), 12'($urandom));
            run_seq($urandom_range(0, 3), 2);
        end

        // Reset while running segment 2
        write_cfg(2, 2, 12'd3);
        i_numSeg = 2'd2; i_loop = 1'b0; i_go = 1'b1;
        tick;
        i_go = 1'b0;
        do_segment(0, 1'b0, 0, 12'd0, 1);
        do_segment(1, 1'b0, 0, 12'd0, 1);
        tick;
        i_swStepping = 1'b1;
        tick;
        i_swStepping = 1'b0; i_reset = 1'b1;
        tick;
        i_reset = 1'b0;
        model_clear();
        chk_idle("midrst", 1'b0);
        chk("midrst_segidx", 32'(o_segIdx), 32'd0);
        chk("midrst_steps", 32'(o_swSteps), 32'd0);
        chk("midrst_start", 32'(o_swStart), 32'd0);
        chk("midrst_updir", 32'(o_swUpdir), 32'd0);
        tick;
        chk_idle("midrst_after", 1'b0);
        run_seq(0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
